hash_writer: RTL
================

# hash_writer

Serializes a completed 256-bit hash vector into HASH_LENGTH 32-bit word writes to the hash/output memory. It is the write-side counterpart of the hash assembly stage, which packs word n at bits [32n+31:32n]. hash_writer unpacks with the same mapping and emits one addressed word per accepted write. It sits after the compression/accumulate stage and before the output memory.

## Interface

**Parameters**
- HASH_LENGTH, 8, number of 32-bit words per hash. The hash vector is 32·HASH_LENGTH bits (256 at default).

**Ports**
- clock, input, 1, single clock; all logic on posedge.
- reset, input, 1, synchronous, active-high; priority over all other inputs.
- enable, input, 1, block enable; low aborts and returns to IDLE.
- hash_vector_complete, input, 1, start request; the vector is valid while high.
- hash_vector, input, 256, hash to write; word n = bits [32n+31:32n].
- write_ready, input, 1, memory accepts the current write this cycle.
- hash_address, output, $clog2(HASH_LENGTH), word address of the current write.
- hash_data, output, 32, word data of the current write.
- hash_write, output, 1, write strobe (valid).
- hash_busy, output, 1, high in WRITE state.
- hash_write_complete, output, 1, all words written; held in DONE.

## Operation

- All outputs are registered.
- Reset values:
  - hash_address=0, hash_data=0, hash_write=0, hash_busy=0, hash_write_complete=0.
  - State=IDLE, word counter=0, shadow register=0.
- **State machine: IDLE, WRITE, DONE.**
- **IDLE**
  - Transition: when enable && hash_vector_complete, capture hash_vector into a 256-bit shadow register and clear the counter.
  - Next state is WRITE.
  - Outputs set in the same edge: hash_write=1, hash_busy=1, hash_address=0, hash_data=shadow word 0 (taken directly from the input).
- **WRITE**
  - Handshake: a word transfers on any cycle with hash_write && write_ready.
  - On transfer with counter < HASH_LENGTH-1:
    - Increment the counter.
    - Present address counter+1 and data word counter+1 on the next cycle.
    - hash_write stays high, so back-to-back writes are one per cycle.
  - On transfer with counter == HASH_LENGTH-1:
    - Next state is DONE; hash_write=0, hash_busy=0, hash_write_complete=1.
    - hash_address and hash_data return to 0.
  - write_ready low: hold hash_address, hash_data and hash_write unchanged (no drop, no skip).
- **DONE**
  - hash_write_complete stays 1 while enable is high.
  - A new start is not accepted in DONE.
  - enable low: next state is IDLE, hash_write_complete=0.
- **Abort**
  - enable low in WRITE or DONE: next edge goes to IDLE with all outputs at their reset values.
  - Partial writes already accepted are not undone.
- Shadow register
  - After capture, changes on hash_vector and hash_vector_complete are ignored until the next IDLE.
  - hash_vector_complete high in WRITE or DONE has no effect.
- Counter
  - Width is $clog2(HASH_LENGTH).
  - It never wraps; the terminal-count check occurs before increment.
- Word selection: hash_data = shadow[32·counter +: 32].

## Timing

- Cycle 0: edge samples the start.
- Cycle 1: first write (address 0) is visible.
- With write_ready held high:
  - Writes occupy cycles 1..HASH_LENGTH (8 cycles at default).
  - hash_write_complete rises in cycle HASH_LENGTH+1 (9).
- Each cycle of write_ready low adds exactly one cycle of latency.
- No combinational path from any input to any output.
- reset mid-WRITE: the next edge gives all outputs their reset values and state IDLE, regardless of enable or write_ready.
- reset and start in the same cycle: reset wins and no capture occurs.

## Test plan

- **Basic write-out.** Word n = 0xA5A50000+n, write_ready tied high, start pulsed.
  - Required: 8 consecutive writes, address 0..7 with matching data, cycles 1–8.
  - Required: hash_write_complete=1 from cycle 9.
- **Backpressure.** write_ready low for 3 cycles while address 2 is presented.
  - Required: address 2 / data 0xA5A50002 held stable with hash_write=1 for those 3 cycles.
  - Required: completion is delayed by exactly 3 cycles and no words are duplicated.
- **Input isolation.** Change hash_vector to all-ones one cycle after the start.
  - Required: all written data still equals the captured words.
- **Abort.** enable dropped after the write to address 4 is accepted.
  - Required: next cycle hash_write=0, hash_busy=0, hash_address=0.
  - Required: when enable rises again and a new start is given, writing restarts at address 0.
- **Reset precedence.** reset asserted mid-WRITE with enable=1 and write_ready=1.
  - Required: all outputs are 0 on the next edge.
  - Required: reset asserted together with a start produces no write.
- **DONE hold.** hash_vector_complete held high after completion.
  - Required: no second write sequence occurs while enable stays high.
  - Required: a new sequence begins only after enable toggles low then high with the start present.

Source files
------------

// File: rtl/hash_writer.sv
// ---- hash_writer: unpacks a captured hash vector into HASH_LENGTH addressed 32-bit word writes ----
// ---- Rev 1.0 ----
`default_nettype none

module hash_writer #(
  parameter int HASH_LENGTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            hash_vector_complete,
  input  logic [32*HASH_LENGTH-1:0]       hash_vector,
  input  logic                            write_ready,
  output logic [$clog2(HASH_LENGTH)-1:0]  hash_address,
  output logic [31:0]                     hash_data,
  output logic                            hash_write,
  output logic                            hash_busy,
  output logic                            hash_write_complete
);

  localparam int AW = $clog2(HASH_LENGTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(HASH_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                        state, state_nx;
  logic [AW-1:0]                 count, count_nx, count_inc;
  logic [HASH_LENGTH-1:0][31:0]  shadow, shadow_nx;
  logic [AW-1:0]                 address_nx;
  logic [31:0]                   data_nx;
  logic                          write_nx, busy_nx, complete_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      count               <= '0;
      shadow              <= '0;
      hash_address        <= '0;
      hash_data           <= '0;
      hash_write          <= 1'b0;
      hash_busy           <= 1'b0;
      hash_write_complete <= 1'b0;
    end else begin
      state               <= state_nx;
      count               <= count_nx;
      shadow              <= shadow_nx;
      hash_address        <= address_nx;
      hash_data           <= data_nx;
      hash_write          <= write_nx;
      hash_busy           <= busy_nx;
      hash_write_complete <= complete_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    shadow_nx   = shadow;
    address_nx  = hash_address;
    data_nx     = hash_data;
    write_nx    = hash_write;
    busy_nx     = hash_busy;
    complete_nx = hash_write_complete;
    count_inc   = count + AW'(1);

    // Dropping enable abandons whatever is in flight; the shadow is simply re-captured on the next start.
    if (!enable) begin
      state_nx    = IDLE;
      count_nx    = '0;
      address_nx  = '0;
      data_nx     = '0;
      write_nx    = 1'b0;
      busy_nx     = 1'b0;
      complete_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hash_vector_complete) begin
            state_nx    = WRITE;
            shadow_nx   = hash_vector;
            count_nx    = '0;
            address_nx  = '0;
            data_nx     = hash_vector[31:0];
            write_nx    = 1'b1;
            busy_nx     = 1'b1;
            complete_nx = 1'b0;
          end
        end
        WRITE: begin
          if (hash_write && write_ready) begin
            if (count == LAST_WORD) begin
              state_nx    = DONE;
              address_nx  = '0;
              data_nx     = '0;
              write_nx    = 1'b0;
              busy_nx     = 1'b0;
              complete_nx = 1'b1;
            end else begin
              count_nx   = count_inc;
              address_nx = count_inc;
              data_nx    = shadow[count_inc];
            end
          end
        end
        DONE: begin
          complete_nx = 1'b1;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
